sar_conversion_controller: RTL and testbench

Sequences one successive-approximation conversion per start request. Samples a comparator decision each cycle and builds the trial code bit by bit. Drives the 2-bit phase bus `StateP` and trial code `SAROut` consumed by the SAR timer/inverter stage. Returns the final code with a one-cycle done strobe.

---
 rtl/sar_pkg.sv | 15 +
 rtl/sar_conversion_controller_if.sv | 28 ++
 rtl/sar_successive_reg.sv | 53 +++++
 rtl/sar_conversion_controller.sv | 142 ++++++++++++++
 tb/tb_sar_conversion_controller.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sar_pkg.sv
// Shared SAR definitions: phase encodings seen on the StateP bus and default sizing.
// Used by the conversion controller and the SAR timer/inverter stage.
package sar_pkg;

  typedef logic [1:0] sar_phase_t;

  localparam logic [1:0] SAR_IDLE    = 2'b00;
  localparam logic [1:0] SAR_SAMPLE  = 2'b01;
  localparam logic [1:0] SAR_CONVERT = 2'b10;
  localparam logic [1:0] SAR_DONE    = 2'b11;

  localparam int SAR_DATA_DEFAULT          = 8;
  localparam int SAR_SAMPLE_CYCLES_DEFAULT = 4;

endpackage

// File: rtl/sar_conversion_controller_if.sv
// Handshake/data bundle between the SAR conversion controller (slave) and its user
// (master): request/abort/comparator in, phase, trial code and result out.
interface sar_conversion_controller_if
  import sar_pkg::*;
#(
  parameter int DATA = SAR_DATA_DEFAULT
);

  logic            Start;
  logic            Abort;
  logic            CompIn;
  logic [1:0]      StateP;
  logic [DATA-1:0] SAROut;
  logic [DATA-1:0] Result;
  logic            Busy;
  logic            Done;

  modport master (
    output Start, Abort, CompIn,
    input  StateP, SAROut, Result, Busy, Done
  );

  modport slave (
    input  Start, Abort, CompIn,
    output StateP, SAROut, Result, Busy, Done
  );

endinterface

// File: rtl/sar_successive_reg.sv
// Successive-approximation register: holds the trial code and the bit pointer.
// Controls: clear (code/pointer to 0), load_msb (start a pass), decide (resolve one bit).
module sar_successive_reg
  import sar_pkg::*;
#(
  parameter int DATA = SAR_DATA_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            load_msb,
  input  logic            decide,
  input  logic            comp_in,
  output logic [DATA-1:0] code,
  output logic [DATA-1:0] resolved,
  output logic            at_lsb
);

  localparam int PW = $clog2(DATA);

  logic [PW-1:0]   ptr;
  logic [DATA-1:0] next_code;

  // Comparator high means the trial overshoots, so the bit under test is dropped.
  always_comb begin
    resolved      = code;
    resolved[ptr] = ~comp_in;
  end

  always_comb begin
    next_code = resolved;
    if (ptr != '0) next_code[ptr - 1'b1] = 1'b1;
  end

  assign at_lsb = (ptr == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code <= '0;
      ptr  <= '0;
    end else if (clear) begin
      code <= '0;
      ptr  <= '0;
    end else if (load_msb) begin
      code <= {1'b1, {(DATA-1){1'b0}}};
      ptr  <= PW'(DATA - 1);
    end else if (decide) begin
      code <= next_code;
      if (ptr != '0) ptr <= ptr - 1'b1;
    end
  end

endmodule

// File: rtl/sar_conversion_controller.sv
// SAR conversion controller: phase FSM, sample counter and result register.
// Define SAR_AVG2_EN to run two SAMPLE+CONVERT passes per Start and report their average.
module sar_conversion_controller
  import sar_pkg::*;
#(
  parameter int DATA          = SAR_DATA_DEFAULT,
  parameter int SAMPLE_CYCLES = SAR_SAMPLE_CYCLES_DEFAULT
) (
  input logic                        ClockT,
  input logic                        Reset,
  sar_conversion_controller_if.slave bus
);

  localparam int            CW          = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
  localparam logic [CW-1:0] SAMPLE_LOAD = CW'(SAMPLE_CYCLES - 1);

  sar_phase_t      phase;
  sar_phase_t      next_phase;
  logic [CW-1:0]   sample_cnt;
  logic [DATA-1:0] result;
  logic            done;
  logic            busy;
  logic            sar_clear;
  logic            sar_load;
  logic            sar_decide;
  logic            at_lsb;
  logic [DATA-1:0] sar_code;
  logic [DATA-1:0] resolved;
  logic [DATA-1:0] final_code;
  logic            start_conv;
  logic            pass_end;
  logic            finish;
  logic            restart;

  sar_successive_reg #(.DATA(DATA)) u_sar (
    .clk      (ClockT),
    .rst      (Reset),
    .clear    (sar_clear),
    .load_msb (sar_load),
    .decide   (sar_decide),
    .comp_in  (bus.CompIn),
    .code     (sar_code),
    .resolved (resolved),
    .at_lsb   (at_lsb)
  );

  assign start_conv = (phase == SAR_IDLE) && bus.Start;
  assign pass_end   = (phase == SAR_CONVERT) && !bus.Abort && at_lsb;

`ifdef SAR_AVG2_EN
  logic            second_pass;
  logic [DATA-1:0] first_code;
  logic [DATA:0]   code_sum;

  assign code_sum   = {1'b0, first_code} + {1'b0, resolved};
  assign final_code = DATA'(code_sum >> 1);
  assign finish     = pass_end && second_pass;
  assign restart    = pass_end && !second_pass;

  // Any return to IDLE (finish or abort) forgets the first pass.
  always_ff @(posedge ClockT or posedge Reset) begin
    if (Reset) begin
      second_pass <= 1'b0;
      first_code  <= '0;
    end else if (restart) begin
      second_pass <= 1'b1;
      first_code  <= resolved;
    end else if (next_phase == SAR_IDLE) begin
      second_pass <= 1'b0;
    end
  end
`else
  assign final_code = resolved;
  assign finish     = pass_end;
  assign restart    = 1'b0;
`endif

  always_comb begin
    next_phase = phase;
    sar_clear  = 1'b0;
    sar_load   = 1'b0;
    sar_decide = 1'b0;
    case (phase)
      SAR_IDLE: begin
        if (bus.Start) next_phase = SAR_SAMPLE;
      end
      SAR_SAMPLE: begin
        if (bus.Abort) begin
          next_phase = SAR_IDLE;
          sar_clear  = 1'b1;
        end else if (sample_cnt == '0) begin
          next_phase = SAR_CONVERT;
          sar_load   = 1'b1;
        end
      end
      SAR_CONVERT: begin
        if (bus.Abort) begin
          next_phase = SAR_IDLE;
          sar_clear  = 1'b1;
        end else if (restart) begin
          next_phase = SAR_SAMPLE;
          sar_clear  = 1'b1;
        end else begin
          sar_decide = 1'b1;
          if (finish) next_phase = SAR_DONE;
        end
      end
      SAR_DONE: begin
        next_phase = SAR_IDLE;
        sar_clear  = 1'b1;
      end
      default: begin
        next_phase = SAR_IDLE;
        sar_clear  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge ClockT or posedge Reset) begin
    if (Reset) begin
      phase      <= SAR_IDLE;
      sample_cnt <= '0;
      result     <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      phase <= next_phase;
      busy  <= (next_phase != SAR_IDLE);
      done  <= finish;
      if (start_conv || restart) sample_cnt <= SAMPLE_LOAD;
      else if (phase == SAR_SAMPLE && sample_cnt != '0) sample_cnt <= sample_cnt - 1'b1;
      if (finish) result <= final_code;
    end
  end

  assign bus.StateP = phase;
  assign bus.SAROut = sar_code;
  assign bus.Result = result;
  assign bus.Busy   = busy;
  assign bus.Done   = done;

endmodule

// File: tb/tb_sar_conversion_controller.sv
// Self-checking bench for sar_conversion_controller: directed cases plus randomized
// Start/Abort traffic against a schedule-based model (honours SAR_AVG2_EN when defined).
module tb_sar_conversion_controller;

  localparam int D = 8;
  localparam int S = 4;
  localparam int L = S + D;
`ifdef SAR_AVG2_EN
  localparam int PASSES = 2;
`else
  localparam int PASSES = 1;
`endif
  localparam int TOTAL = PASSES * L;

  logic ClockT;
  logic Reset;
  logic check_en;
  logic [D-1:0] vin0;
  logic [D-1:0] vin1;
  logic [D-1:0] cmp_ref;

  int vectors;
  int miscompares;

  // Model: m_age counts cycles since the accepted Start (0 = idle).
  int           m_age;
  logic [D-1:0] m_v [2];
  logic [D-1:0] m_result;

  logic [1:0]   e_sp;
  logic [D-1:0] e_so;
  logic         e_busy;
  logic         e_done;
  int           e_pass;
  int           e_off;

  int           done_at;
  int           n_done;
  int           busy_cnt;
  int           cnt_sample;
  int           cnt_conv;
  int           cnt_dph;
  int           tr_n;
  logic [D-1:0] trace     [D];
  logic [D-1:0] exp_trace [D];
  int           done_times[$];

  sar_conversion_controller_if #(.DATA(D)) bus ();

  sar_conversion_controller #(.DATA(D), .SAMPLE_CYCLES(S)) dut (
    .ClockT (ClockT),
    .Reset  (Reset),
    .bus    (bus)
  );

  // Comparator: high when the trial code exceeds the analog input.
  assign bus.CompIn = (bus.SAROut > cmp_ref);

  initial ClockT = 1'b0;
  always #5 ClockT = ~ClockT;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [D-1:0] trial_code(input logic [D-1:0] v, input int j);
    int keep;
    keep = (int'(v) >> (D - j)) << (D - j);
    return D'(keep | (1 << (D - 1 - j)));
  endfunction

  always @(posedge ClockT or posedge Reset) begin
    if (Reset) begin
      m_age    = 0;
      m_result = '0;
    end else if (m_age == 0) begin
      if (bus.Start) begin
        m_age  = 1;
        m_v[0] = vin0;
        m_v[1] = vin1;
      end
    end else if (m_age <= TOTAL && bus.Abort) begin
      m_age = 0;
    end else if (m_age == TOTAL + 1) begin
      m_age = 0;
    end else begin
      m_age = m_age + 1;
      if (m_age == TOTAL + 1)
        m_result = (PASSES == 2) ? D'((int'(m_v[0]) + int'(m_v[1])) >> 1) : m_v[0];
    end
  end

  always @(negedge ClockT) begin
    e_pass = 0;
    e_off  = 0;
    if (m_age == 0) begin
      e_sp = 2'b00; e_so = '0; e_busy = 1'b0; e_done = 1'b0;
    end else if (m_age == TOTAL + 1) begin
      e_sp = 2'b11; e_so = m_v[PASSES-1]; e_busy = 1'b1; e_done = 1'b1;
      e_pass = PASSES - 1;
    end else begin
      e_pass = (m_age - 1) / L;
      e_off  = (m_age - 1) % L;
      e_busy = 1'b1;
      e_done = 1'b0;
      if (e_off < S) begin
        e_sp = 2'b01; e_so = '0;
      end else begin
        e_sp = 2'b10; e_so = trial_code(m_v[e_pass], e_off - S);
      end
    end
    cmp_ref = m_v[e_pass];
    if (check_en) begin
      check_output("model StateP", bus.StateP, e_sp);
      check_output("model SAROut", bus.SAROut, e_so);
      check_output("model Busy",   bus.Busy,   e_busy);
      check_output("model Done",   bus.Done,   e_done);
      check_output("model Result", bus.Result, m_result);
    end
  end

  // Pulse Start from idle and record what the DUT does over the following cycles.
  task automatic apply_stimulus(input logic [D-1:0] v0, input logic [D-1:0] v1);
    vin0 = v0;
    vin1 = v1;
    done_at = -1; n_done = 0; busy_cnt = 0;
    cnt_sample = 0; cnt_conv = 0; cnt_dph = 0; tr_n = 0;
    bus.Start = 1'b1;
    for (int c = 1; c <= TOTAL + 6; c++) begin
      @(negedge ClockT);
      bus.Start = 1'b0;
      if (bus.Busy) busy_cnt++;
      if (bus.StateP == 2'b01) cnt_sample++;
      if (bus.StateP == 2'b11) cnt_dph++;
      if (bus.StateP == 2'b10) begin
        cnt_conv++;
        if (tr_n < D) begin
          trace[tr_n] = bus.SAROut;
          tr_n++;
        end
      end
      if (bus.Done) begin
        n_done++;
        done_at = c - 1;
      end
    end
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 40 && bus.StateP != 2'b00; c++) @(negedge ClockT);
    check_output("wait_idle StateP", bus.StateP, 2'b00);
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    check_en = 1'b0;
    bus.Start = 1'b0; bus.Abort = 1'b0;
    vin0 = '0; vin1 = '0; cmp_ref = '0;
    exp_trace = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
    Reset = 1'b0;
    #2 Reset = 1'b1;
    @(negedge ClockT);
    @(negedge ClockT);
    Reset = 1'b0;
    check_en = 1'b1;
    $display("[TB] reset released");
    check_output("reset StateP", bus.StateP, 2'b00);
    check_output("reset SAROut", bus.SAROut, 8'h00);
    check_output("reset Result", bus.Result, 8'h00);
    check_output("reset Busy",   bus.Busy,   1'b0);
    check_output("reset Done",   bus.Done,   1'b0);

`ifdef SAR_AVG2_EN
    apply_stimulus(8'h40, 8'h43);
    check_output("avg latency", done_at, 24);
    check_output("avg done count", n_done, 1);
    check_output("avg Result", bus.Result, 8'h41);
`else
    apply_stimulus(8'hA5, 8'hA5);
    check_output("A5 latency", done_at, 12);
    check_output("A5 done count", n_done, 1);
    check_output("A5 busy cycles", busy_cnt, 13);
    check_output("A5 sample cycles", cnt_sample, 4);
    check_output("A5 convert cycles", cnt_conv, 8);
    check_output("A5 done phase cycles", cnt_dph, 1);
    check_output("A5 Result", bus.Result, 8'hA5);
    for (int i = 0; i < D; i++) check_output($sformatf("A5 trial %0d", i), trace[i], exp_trace[i]);

    apply_stimulus(8'h00, 8'h00);
    check_output("00 Result", bus.Result, 8'h00);
    check_output("00 busy cycles", busy_cnt, 13);
    apply_stimulus(8'hFF, 8'hFF);
    check_output("FF Result", bus.Result, 8'hFF);
    check_output("FF busy cycles", busy_cnt, 13);

    // Abort on the 3rd CONVERT cycle.
    vin0 = 8'h5A; vin1 = 8'h5A;
    bus.Start = 1'b1;
    @(negedge ClockT);
    bus.Start = 1'b0;
    repeat (6) @(negedge ClockT);
    check_output("abort pre StateP", bus.StateP, 2'b10);
    bus.Abort = 1'b1;
    @(negedge ClockT);
    bus.Abort = 1'b0;
    check_output("abort StateP", bus.StateP, 2'b00);
    check_output("abort SAROut", bus.SAROut, 8'h00);
    check_output("abort Result", bus.Result, 8'hFF);
    n_done = 0;
    repeat (16) @(negedge ClockT) if (bus.Done) n_done++;
    check_output("abort no Done", n_done, 0);

    // Asynchronous reset mid-CONVERT.
    vin0 = 8'h3C; vin1 = 8'h3C;
    bus.Start = 1'b1;
    @(negedge ClockT);
    bus.Start = 1'b0;
    repeat (7) @(negedge ClockT);
    #2 Reset = 1'b1;
    #1;
    check_output("async reset StateP", bus.StateP, 2'b00);
    check_output("async reset SAROut", bus.SAROut, 8'h00);
    check_output("async reset Result", bus.Result, 8'h00);
    check_output("async reset Busy",   bus.Busy,   1'b0);
    check_output("async reset Done",   bus.Done,   1'b0);
    @(negedge ClockT);
    Reset = 1'b0;
    apply_stimulus(8'h3C, 8'h3C);
    check_output("post-reset Result", bus.Result, 8'h3C);

    // Start held high continuously.
    vin0 = 8'h96; vin1 = 8'h96;
    done_times.delete();
    bus.Start = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      @(negedge ClockT);
      if (bus.Done) done_times.push_back(c);
    end
    bus.Start = 1'b0;
    check_output("held done count", done_times.size(), 3);
    for (int i = 1; i < done_times.size(); i++)
      check_output("held period", done_times[i] - done_times[i-1], 14);
    wait_idle();
`endif

    // Randomized Start/Abort traffic; input code only changes while idle.
    for (int c = 0; c < 500; c++) begin
      @(negedge ClockT);
      if (m_age == 0) begin
        case ($urandom_range(0, 3))
          0:       begin vin0 = 8'h00; vin1 = 8'hFF; end
          1:       begin vin0 = 8'hFF; vin1 = 8'hFF; end
          default: begin vin0 = D'($urandom); vin1 = D'($urandom); end
        endcase
      end
      bus.Start = ($urandom_range(0, 5) == 0);
      bus.Abort = ($urandom_range(0, 24) == 0);
    end
    bus.Start = 1'b0;
    bus.Abort = 1'b0;
    wait_idle();
    repeat (2) @(negedge ClockT);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: bench did not reach its summary");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
